// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Definitions shared by the SPI read and write paths.
//
// Contents:
//   ST_IDLE/ST_SETUP/ST_SHIFT/ST_HOLD : transfer state encodings
//   spi_state_e                       : enumerated state type built on them
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        SHIFT = ST_SHIFT,
        HOLD  = ST_HOLD
    } spi_state_e;

endpackage

// File: rtl/spi_read_if.sv
// -----------------------------------------------------------------------------
// spi_read_if
// Serial-side bundle between the SPI master reader and the slave device.
//
// Signals:
//   sclk_o  serial clock, CPOL=0 (driven by master)
//   cs_o    chip select, active-low (driven by master)
//   miso_i  serial data from slave to master
// Modports:
//   master  drives sclk_o/cs_o, samples miso_i
//   slave   samples sclk_o/cs_o, drives miso_i
// -----------------------------------------------------------------------------
interface spi_read_if;

    logic sclk_o;
    logic cs_o;
    logic miso_i;

    modport master (
        output sclk_o,
        output cs_o,
        input  miso_i
    );

    modport slave (
        input  sclk_o,
        input  cs_o,
        output miso_i
    );

endinterface

// File: rtl/spi_read_sclk_tick.sv
// -----------------------------------------------------------------------------
// sclk_tick
// Loadable down-counter that paces the serial clock. A load captures kmax_i
// both as the running count and as the reload value, so later changes on
// kmax_i do not disturb a transfer in flight. While enabled the count
// decrements every cycle; when it reaches zero tick_o is high for that cycle
// and the count reloads, giving one tick every (kmax+1) cycles.
//
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-low reset
//   load_i   capture kmax_i into count and reload register
//   kmax_i   half-period minus one, in clk_i cycles
//   en_i     count enable
//   tick_o   high in the cycle the enabled count is zero
// -----------------------------------------------------------------------------
module sclk_tick #(
    parameter int DivWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [DivWidth-1:0] kmax_i,
    input  logic                en_i,
    output logic                tick_o
);

    logic [DivWidth-1:0] cnt_reg;
    logic [DivWidth-1:0] kmax_reg;

    assign tick_o = en_i && (cnt_reg == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_reg  <= '0;
            kmax_reg <= '0;
        end else if (load_i) begin
            cnt_reg  <= kmax_i;
            kmax_reg <= kmax_i;
        end else if (en_i) begin
            if (cnt_reg == '0) begin
                cnt_reg <= kmax_reg;
            end else begin
                cnt_reg <= cnt_reg - DivWidth'(1);
            end
        end
    end

endmodule

// File: rtl/spi_read.sv
// -----------------------------------------------------------------------------
// spi_read
// SPI mode-0 master reader. A start request in IDLE drops chip select,
// runs Width serial clock cycles at a rate set by kmax_i, shifts miso_i in
// on every SCLK rising edge and finally presents the word on data_o with a
// one-cycle valid_o strobe. Chip select is held low for one tick period
// before the first rising edge and after the last falling edge.
//
// Parameters:
//   Width     bits per transfer (>= 2)
//   DivWidth  width of kmax_i
// Ports:
//   clk_i     system clock
//   rst_i     asynchronous active-low reset
//   start_i   read request, accepted only in IDLE
//   kmax_i    SCLK half-period minus one, latched at start
//   data_o    last received word, held until the next completed transfer
//   valid_o   one-cycle pulse when data_o is updated
//   busy_o    transfer in progress
//   spi       serial bus (sclk_o, cs_o, miso_i), master side
//
// Build option:
//   SPI_READ_LSB_FIRST_EN  defined -> first received bit lands in data_o[0];
//                          undefined -> first bit lands in data_o[Width-1].
// -----------------------------------------------------------------------------
module spi_read
    import spi_pkg::*;
#(
    parameter int Width    = 16,
    parameter int DivWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [DivWidth-1:0] kmax_i,
    output logic [Width-1:0]    data_o,
    output logic                valid_o,
    output logic                busy_o,
    spi_read_if.master          spi
);

    localparam int CntW = (Width > 2) ? $clog2(Width) : 1;

    spi_state_e        state_reg, state_next;
    logic              sclk_reg, sclk_next;
    logic              cs_reg, cs_next;
    logic              busy_reg, busy_next;
    logic              valid_reg, valid_next;
    logic [Width-1:0]  data_reg, data_next;
    logic [Width-1:0]  shreg_reg, shreg_next;
    logic [CntW-1:0]   bit_cnt_reg, bit_cnt_next;

    logic              tick;
    logic              tick_load;
    logic              tick_en;

    // Insert one received bit into the shift register.
    function automatic logic [Width-1:0] shift_in(input logic [Width-1:0] sr,
                                                  input logic             b);
`ifdef SPI_READ_LSB_FIRST_EN
        return {b, sr[Width-1:1]};
`else
        return {sr[Width-2:0], b};
`endif
    endfunction

    // The tick counter only runs while a transfer is active; in IDLE it
    // waits for the load that accompanies an accepted start.
    assign tick_en = (state_reg != IDLE);

    sclk_tick #(
        .DivWidth (DivWidth)
    ) u_sclk_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (tick_load),
        .kmax_i (kmax_i),
        .en_i   (tick_en),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg   <= IDLE;
            sclk_reg    <= 1'b0;
            cs_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            data_reg    <= '0;
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            sclk_reg    <= sclk_next;
            cs_reg      <= cs_next;
            busy_reg    <= busy_next;
            valid_reg   <= valid_next;
            data_reg    <= data_next;
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sclk_next    = sclk_reg;
        cs_next      = cs_reg;
        busy_next    = busy_reg;
        valid_next   = 1'b0;
        data_next    = data_reg;
        shreg_next   = shreg_reg;
        bit_cnt_next = bit_cnt_reg;
        tick_load    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next   = SETUP;
                    cs_next      = 1'b0;
                    busy_next    = 1'b1;
                    tick_load    = 1'b1;
                    bit_cnt_next = '0;
                    shreg_next   = '0;
                end
            end

            // First tick ends the CS setup time with the first rising edge,
            // which is also the first sampling point.
            SETUP: begin
                if (tick) begin
                    state_next = SHIFT;
                    sclk_next  = 1'b1;
                    shreg_next = shift_in(shreg_reg, spi.miso_i);
                end
            end

            SHIFT: begin
                if (tick) begin
                    if (sclk_reg) begin
                        // Falling edge: one bit completed.
                        sclk_next = 1'b0;
                        if (bit_cnt_reg == CntW'(Width - 1)) begin
                            state_next   = HOLD;
                            bit_cnt_next = '0;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + CntW'(1);
                        end
                    end else begin
                        sclk_next  = 1'b1;
                        shreg_next = shift_in(shreg_reg, spi.miso_i);
                    end
                end
            end

            HOLD: begin
                if (tick) begin
                    state_next = IDLE;
                    cs_next    = 1'b1;
                    busy_next  = 1'b0;
                    valid_next = 1'b1;
                    data_next  = shreg_reg;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign spi.sclk_o = sclk_reg;
    assign spi.cs_o   = cs_reg;
    assign data_o     = data_reg;
    assign valid_o    = valid_reg;
    assign busy_o     = busy_reg;

endmodule

// File: tb/tb_spi_read.sv
// -----------------------------------------------------------------------------
// tb_spi_read
// Self-checking bench for spi_read. A behavioural slave shifts words out on
// falling SCLK; expected words and completion cycles are queued when a start
// is driven and compared when valid_o appears.
// -----------------------------------------------------------------------------
module tb_spi_read;

    localparam int W  = 16;
    localparam int DW = 8;

    logic          clk_i   = 1'b0;
    logic          rst_i   = 1'b0;
    logic          start_i = 1'b0;
    logic [DW-1:0] kmax_i  = '0;
    logic [W-1:0]  data_o;
    logic          valid_o;
    logic          busy_o;
    logic          miso    = 1'b0;

    spi_read_if spi_bus ();
    assign spi_bus.miso_i = miso;

    spi_read #(
        .Width    (W),
        .DivWidth (DW)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .kmax_i  (kmax_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .busy_o  (busy_o),
        .spi     (spi_bus)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] slave_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    bit           b2b_mode = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_word(input logic [W-1:0] w);
        logic [W-1:0] r;
`ifdef SPI_READ_LSB_FIRST_EN
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
`else
        r = w;
`endif
        return r;
    endfunction

    function automatic int lat(input int k);
        return (2 * W + 1) * (k + 1);
    endfunction

    // Slave: MSB on CS fall, next bit after each SCLK falling edge.
    initial begin
        logic [W-1:0] cur;
        int           idx;
        bit           active;
        logic         prev_sclk;
        cur = '0; idx = 0; active = 1'b0; prev_sclk = 1'b0;
        forever begin
            @(negedge clk_i);
            if (spi_bus.cs_o !== 1'b0) begin
                active = 1'b0;
            end else if (!active) begin
                active = 1'b1;
                idx    = 0;
                cur    = (slave_q.size() > 0) ? slave_q.pop_front() : '0;
                miso   = cur[W-1];
            end else if (prev_sclk && !spi_bus.sclk_o) begin
                idx++;
                if (idx < W) miso = cur[W-1-idx];
            end
            prev_sclk = spi_bus.sclk_o;
        end
    end

    // Monitor: valid pulses, SCLK rising edges, CS gap between transfers.
    initial begin
        int   rise_cnt;
        int   cs_run;
        logic prev_valid;
        logic prev_sclk;
        logic prev_cs;
        exp_t e;
        rise_cnt = 0; cs_run = 0; prev_valid = 1'b0; prev_sclk = 1'b0; prev_cs = 1'b1;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                rise_cnt = 0; cs_run = 0; prev_valid = 1'b0; prev_sclk = 1'b0; prev_cs = 1'b1;
            end else begin
                if (spi_bus.sclk_o && !prev_sclk) rise_cnt++;
                if (prev_valid) check_eq("valid_width", 32'(valid_o), 32'd0);
                if (spi_bus.cs_o) begin
                    cs_run++;
                end else begin
                    if (prev_cs && b2b_mode) check_eq("cs_gap", 32'(cs_run), 32'd1);
                    cs_run = 0;
                end
                if (valid_o) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_valid", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("data", 32'(data_o), 32'(e.data));
                        check_eq("latency", 32'(cyc), 32'(e.due));
                        check_eq("cs_at_valid", 32'(spi_bus.cs_o), 32'd1);
                        check_eq("busy_at_valid", 32'(busy_o), 32'd0);
                        check_eq("sclk_rises", 32'(rise_cnt), 32'(W));
                        $display("xfer: data=0x%04h exp=0x%04h cycle=%0d due=%0d rises=%0d",
                                 data_o, e.data, cyc, e.due, rise_cnt);
                    end
                    rise_cnt = 0;
                end
                prev_valid = valid_o;
                prev_sclk  = spi_bus.sclk_o;
                prev_cs    = spi_bus.cs_o;
            end
        end
    end

    task automatic start_xfer(input logic [W-1:0] w, input int k);
        exp_t e;
        @(negedge clk_i);
        e.data = model_word(w);
        e.due  = cyc + 1 + lat(k);
        slave_q.push_back(w);
        exp_q.push_back(e);
        kmax_i  = DW'(k);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_sclk"},  32'(spi_bus.sclk_o), 32'd0);
        check_eq({tag, "_cs"},    32'(spi_bus.cs_o),   32'd1);
        check_eq({tag, "_valid"}, 32'(valid_o),        32'd0);
        check_eq({tag, "_busy"},  32'(busy_o),         32'd0);
    endtask

    initial begin
        logic [W-1:0] words[3];
        exp_t         e;
        int           due;
        int           nv;
        int           guard;

        // Reset state
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_idle("reset");
        check_eq("reset_data", 32'(data_o), 32'd0);
        rst_i = 1'b1;

        // Nominal transfer, kmax=3 -> 132 cycles
        start_xfer(16'hA5C3, 3);
        wait_drain(400);

        // Fastest rate, kmax=0 -> 33 cycles
        start_xfer(16'h3C5A, 0);
        wait_drain(100);

        // start_i and kmax_i disturbed mid-transfer: no restart, same period
        start_xfer(16'h1234, 2);
        repeat (20) @(negedge clk_i);
        start_i = 1'b1;
        kmax_i  = 8'd0;
        @(negedge clk_i);
        start_i = 1'b0;
        kmax_i  = 8'd7;
        check_eq("mid_busy", 32'(busy_o), 32'd1);
        wait_drain(400);
        repeat (10) @(negedge clk_i);
        check_idle("after_mid");

        // Reset while SCLK is high during bit 7
        start_xfer(16'h0F0F, 3);
        repeat (61) @(negedge clk_i);
        check_eq("pre_rst_sclk", 32'(spi_bus.sclk_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check_idle("abort");
        check_eq("abort_data", 32'(data_o), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_eq("abort_data_hold", 32'(data_o), 32'd0);
        start_xfer(16'hBEEF, 1);
        wait_drain(200);

        // start_i held high: three back-to-back transfers
        for (int i = 0; i < 3; i++) words[i] = W'($urandom);
        @(negedge clk_i);
        due = cyc;
        for (int i = 0; i < 3; i++) begin
            due    = due + 1 + lat(1);
            e.data = model_word(words[i]);
            e.due  = due;
            exp_q.push_back(e);
            slave_q.push_back(words[i]);
        end
        kmax_i  = 8'd1;
        start_i = 1'b1;
        @(negedge clk_i);
        b2b_mode = 1'b1;
        nv = 0;
        guard = 0;
        while (nv < 3 && guard < 1000) begin
            @(negedge clk_i);
            guard++;
            if (valid_o) begin
                nv++;
                if (nv == 3) start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        if (nv != 3) check_eq("b2b_timeout", 32'(nv), 32'd3);
        b2b_mode = 1'b0;
        wait_drain(50);
        repeat (5) @(negedge clk_i);
        check_idle("after_b2b");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_read.md
# spi_read

SPI mode-0 master reader: on a start pulse it drives chip-select low, generates `Width` serial clock cycles at a programmable rate, shifts in `miso_i`, and presents the captured word with a one-cycle valid strobe. It is the read-direction counterpart of the SPI write path and sits between an SPI slave device (ADC, sensor) and the FPGA-side consumer. The serial clock rate is derived internally from a half-period count.

## Interface
- `Width`, 16, bits per read transfer (≥2)
- `DivWidth`, 8, width of the half-period count `kmax_i`
- `clk_i`  input  1  system clock; all logic on rising edge
- `rst_i`  input  1  asynchronous, active-low reset
- `start_i`  input  1  request a read; accepted only in IDLE
- `kmax_i`  input  DivWidth  SCLK half-period minus one, in `clk_i` cycles; latched at start
- `miso_i`  input  1  serial data from slave
- `sclk_o`  output  1  serial clock, idles low (CPOL=0)
- `cs_o`  output  1  chip select, active-low, idles high
- `data_o`  output  Width  last received word; held until next completed transfer
- `valid_o`  output  1  one-cycle pulse, `data_o` updated
- `busy_o`  output  1  transfer in progress

## Operation
- States: IDLE, SETUP, SHIFT, HOLD.
- IDLE: `cs_o`=1, `sclk_o`=0. `start_i`=1 at edge T0 → SETUP; `cs_o`=0, `busy_o`=1, `kmax_i` latched, tick counter loaded with latched value.
- Tick: counter decrements each cycle; tick when counter==0, counter reloads latched kmax. Ticks at edges T0+n·(kmax+1), n≥1. kmax=0 → tick every cycle.
- SETUP: tick 1 → SHIFT, `sclk_o` rises.
- SHIFT: each tick toggles `sclk_o`. At each rising-edge tick, `miso_i` (value present before that edge) shifts into the shift register, MSB first. Falling-edge ticks increment the bit count; after the `Width`-th falling edge (tick 2·Width) → HOLD.
- HOLD: next tick (2·Width+1) → IDLE; same edge: `cs_o`=1, `data_o`←shift register, `valid_o`=1 for one cycle, `busy_o`=0.
- `start_i` while busy ignored (not queued). `start_i` high in the cycle `valid_o` is high is accepted (back-to-back).
- Changes on `kmax_i` during a transfer have no effect.

## Timing
- Reset values: `sclk_o`=0, `cs_o`=1, `data_o`=0, `valid_o`=0, `busy_o`=0, state IDLE, counters 0.
- Latency start→valid: `valid_o` high after edge T0+(2·Width+1)·(kmax+1). Width=16, kmax=3 → 132 cycles.
- SCLK period 2·(kmax+1) cycles, 50% duty. CS setup and hold before first rise and after last fall: (kmax+1) cycles each.
- All outputs registered; no combinational input→output path.
- Reset asserted mid-transfer: immediate return to IDLE with reset values; partial word discarded, no `valid_o`.

## Configuration
- `SPI_READ_LSB_FIRST_EN`: defined → first received bit lands in `data_o[0]` (LSB-first). Undefined → first bit lands in `data_o[Width-1]` (MSB-first, default). Timing unaffected.

## Structure
- Shared package/include `spi_pkg`: state encoding localparams (IDLE, SETUP, SHIFT, HOLD), shared with the write path.
- One sub-module `sclk_tick`: loadable down-counter producing the tick from `kmax`, enable and reload inputs.

## Test plan
- Width=16, kmax=3, slave drives 0xA5C3 MSB-first on falling SCLK → `data_o`=0xA5C3, `valid_o` one cycle at edge T0+132, `cs_o` high same edge.
- kmax=0 → SCLK toggles every cycle, 16 rising edges, valid at T0+33, correct word.
- `start_i` pulsed mid-transfer and `kmax_i` changed mid-transfer → no restart, period unchanged, single `valid_o`.
- `rst_i` low during SHIFT bit 7 → outputs at reset values next cycle, `data_o`=0, no `valid_o`; new start completes normally.
- `start_i` held high continuously → back-to-back transfers, `cs_o` high exactly one cycle between them, each `valid_o` one cycle.
- With `SPI_READ_LSB_FIRST_EN`, serial stream of 0xA5C3 MSB-first → `data_o`=0xC3A5.
